uart_cmd_parser: RTL and testbench

Byte-level command parser between the UART receiver and the display/LED logic. It consumes one-cycle byte strobes from the receiver and assembles short ASCII frames terminated by CR. Validated frames update the four seven-segment digits or the LED bar atomically. Every frame produces a one-byte response (`!` ok, `?` error, `T` timeout) handed to the UART transmitter with a start/busy handshake.

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_resp_slot.sv | 58 +++++
 rtl/uart_cmd_parser.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_8  = 8'h38;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [7:0] RESP_OK  = 8'h21;  // '!'
  localparam logic [7:0] RESP_ERR = 8'h3F;  // '?'
  localparam logic [7:0] RESP_TMO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_ARGS,
    ST_L_ARG,
    ST_WAIT_CR,
    ST_DISCARD
  } state_t;

  // Thermometer code with n low bits set, n in 0..8.
  function automatic logic [7:0] therm8(input logic [3:0] n);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (n > 4'(i));
    return r;
  endfunction

endpackage

// File: rtl/uart_resp_slot.sv
// Single-entry response slot: holds one pending byte and hands it to the
// transmitter with a one-cycle start pulse, followed by a guard cycle that
// masks the transmitter's registered busy flag.
module uart_resp_slot (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       raise,
  input  logic [7:0] raise_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       overrun
);

  logic       pend_q, pend_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       guard_q, guard_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overrun_q, overrun_d;
  logic       fire;

  // Next-state: a raise in the same cycle as a launch refills the slot
  // without counting as an overrun.
  always_comb begin
    fire        = pend_q && !guard_q && !tx_busy;
    pend_d      = raise || (pend_q && !fire);
    pend_data_d = raise ? raise_data : pend_data_q;
    tx_start_d  = fire;
    guard_d     = fire;
    tx_data_d   = fire ? pend_data_q : tx_data_q;
    overrun_d   = overrun_q || (raise && pend_q && !fire);
  end

  // Slot registers.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      guard_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      guard_q     <= guard_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: assembles CR-terminated D/L frames from UART bytes
// into shadow registers and commits them atomically to Digits/LED.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | between frames, waiting for a command letter
// ST_D_ARGS  | collecting the four display digits
// ST_L_ARG   | waiting for the single LED-bar digit
// ST_WAIT_CR | arguments complete, CR commits the frame
// ST_DISCARD | bad frame, dropping bytes until CR
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        Clk_100M,
  input  logic        Reset,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  input  logic        Tx_Busy,
  output logic [7:0]  Tx_Data,
  output logic        Tx_Start,
  output logic [15:0] Digits,
  output logic [7:0]  LED,
  output logic        Frame_Err,
  output logic        Overrun
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  led_arg_q, led_arg_d;
  logic        is_led_q, is_led_d;
  logic [15:0] digits_q, digits_d;
  logic [7:0]  led_q, led_d;
  logic        frame_err_q, frame_err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic        raise;
  logic [7:0]  raise_data;
  logic        is_digit, is_led_digit;

  assign is_digit     = (Rx_Data >= ASCII_0) && (Rx_Data <= ASCII_9);
  assign is_led_digit = (Rx_Data >= ASCII_0) && (Rx_Data <= ASCII_8);

  // Frame parsing, idle-gap timer (down-counter, expires at zero) and commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    led_arg_d   = led_arg_q;
    is_led_d    = is_led_q;
    digits_d    = digits_q;
    led_d       = led_q;
    frame_err_d = frame_err_q;
    raise       = 1'b0;
    raise_data  = RESP_OK;

    if (Rx_Valid || state_q == ST_IDLE) tmr_d = TMR_LOAD;
    else if (tmr_q != '0)               tmr_d = tmr_q - 1'b1;
    else                                tmr_d = tmr_q;

    if (Rx_Valid && Rx_Data != ASCII_LF) begin
      case (state_q)
        ST_IDLE: begin
          if (Rx_Data == ASCII_D) begin
            state_d  = ST_D_ARGS;
            cnt_d    = 2'd0;
            is_led_d = 1'b0;
          end else if (Rx_Data == ASCII_L) begin
            state_d  = ST_L_ARG;
            is_led_d = 1'b1;
          end else if (Rx_Data != ASCII_CR) begin
            state_d = ST_DISCARD;
          end
        end
        ST_D_ARGS: begin
          if (is_digit) begin
            // Shift in from the right so the first digit ends up leftmost.
            shadow_d = {shadow_q[11:0], Rx_Data[3:0]};
            cnt_d    = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ST_WAIT_CR;
          end else if (Rx_Data == ASCII_CR) begin
            state_d    = ST_IDLE;
            raise      = 1'b1;
            raise_data = RESP_ERR;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_L_ARG: begin
          if (is_led_digit) begin
            led_arg_d = Rx_Data[3:0];
            state_d   = ST_WAIT_CR;
          end else if (Rx_Data == ASCII_CR) begin
            state_d    = ST_IDLE;
            raise      = 1'b1;
            raise_data = RESP_ERR;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_WAIT_CR: begin
          if (Rx_Data == ASCII_CR) begin
            if (is_led_q) led_d = therm8(led_arg_q);
            else          digits_d = shadow_q;
            state_d    = ST_IDLE;
            raise      = 1'b1;
            raise_data = RESP_OK;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (Rx_Data == ASCII_CR) begin
            state_d    = ST_IDLE;
            raise      = 1'b1;
            raise_data = RESP_ERR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (!Rx_Valid && state_q != ST_IDLE && tmr_q == '0) begin
      state_d    = ST_IDLE;
      shadow_d   = '0;
      led_arg_d  = '0;
      raise      = 1'b1;
      raise_data = RESP_TMO;
    end

    if (raise && raise_data != RESP_OK) frame_err_d = 1'b1;
  end

  // Parser and output registers.
  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      led_arg_q   <= 4'h0;
      is_led_q    <= 1'b0;
      digits_q    <= 16'h0000;
      led_q       <= 8'h00;
      frame_err_q <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      led_arg_q   <= led_arg_d;
      is_led_q    <= is_led_d;
      digits_q    <= digits_d;
      led_q       <= led_d;
      frame_err_q <= frame_err_d;
      tmr_q       <= tmr_d;
    end
  end

  uart_resp_slot u_resp_slot (
    .clk_sys    (Clk_100M),
    .rst_b      (Reset),
    .raise      (raise),
    .raise_data (raise_data),
    .tx_busy    (Tx_Busy),
    .tx_start   (Tx_Start),
    .tx_data    (Tx_Data),
    .overrun    (Overrun)
  );

  assign Digits    = digits_q;
  assign LED       = led_q;
  assign Frame_Err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a frame table plus hand sequences for
// timeout, busy/overrun and reset corner cases. In stimulus strings '#' is CR
// and '~' is LF.
module tb_uart_cmd_parser;

  localparam int T = 20;
  localparam logic [7:0] NONE = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [15:0] digits;
  logic [7:0]  led;
  logic        frame_err;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_edge = 0;
  int cr_edge   = 0;
  logic [7:0] rq[$];
  int         rc[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .Clk_100M  (clk),
    .Reset     (rst_n),
    .Rx_Data   (rx_data),
    .Rx_Valid  (rx_valid),
    .Tx_Busy   (tx_busy),
    .Tx_Data   (tx_data),
    .Tx_Start  (tx_start),
    .Digits    (digits),
    .LED       (led),
    .Frame_Err (frame_err),
    .Overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      rq.push_back(tx_data);
      rc.push_back(cyc);
    end
  end

  typedef struct {
    string       s;
    logic [15:0] dig;
    logic [7:0]  led;
    logic [7:0]  resp;
    logic        ferr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] map_ch(input byte c);
    if (c == "#") return 8'h0D;
    if (c == "~") return 8'h0A;
    return 8'(c);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    last_edge = cyc;
    if (b == 8'h0D) cr_edge = cyc;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(map_ch(s[i]));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_resp();
    rq.delete();
    rc.delete();
  endtask

  task automatic chk_one_resp(input string name, input logic [7:0] exp);
    chk({name, "_count"}, rq.size(), 1);
    if (rq.size() > 0) chk({name, "_byte"}, int'(rq[0]), int'(exp));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_digits"}, int'(digits), 0);
    chk({name, "_led"}, int'(led), 0);
    chk({name, "_tx_data"}, int'(tx_data), 0);
    chk({name, "_tx_start"}, int'(tx_start), 0);
    chk({name, "_frame_err"}, int'(frame_err), 0);
    chk({name, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    vecs[0]  = '{"D1234#~", 16'h1234, 8'h00, "!", 1'b0};
    vecs[1]  = '{"L5#",     16'h1234, 8'h1F, "!", 1'b0};
    vecs[2]  = '{"L9#",     16'h1234, 8'h1F, "?", 1'b1};
    vecs[3]  = '{"L0#",     16'h1234, 8'h00, "!", 1'b1};
    vecs[4]  = '{"L8#",     16'h1234, 8'hFF, "!", 1'b1};
    vecs[5]  = '{"D12A#",   16'h1234, 8'hFF, "?", 1'b1};
    vecs[6]  = '{"D9876#",  16'h9876, 8'hFF, "!", 1'b1};
    vecs[7]  = '{"d1#",     16'h9876, 8'hFF, "?", 1'b1};
    vecs[8]  = '{"D12#",    16'h9876, 8'hFF, "?", 1'b1};
    vecs[9]  = '{"L#",      16'h9876, 8'hFF, "?", 1'b1};
    vecs[10] = '{"D98765#", 16'h9876, 8'hFF, "?", 1'b1};
    vecs[11] = '{"~~L~3#",  16'h9876, 8'h07, "!", 1'b1};
    vecs[12] = '{"#",       16'h9876, 8'h07, NONE, 1'b1};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    idle(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Frame table
    for (int v = 0; v < 13; v++) begin
      clear_resp();
      send_str(vecs[v].s);
      idle(4);
      chk($sformatf("v%0d_digits", v), int'(digits), int'(vecs[v].dig));
      chk($sformatf("v%0d_led", v), int'(led), int'(vecs[v].led));
      chk($sformatf("v%0d_frame_err", v), int'(frame_err), int'(vecs[v].ferr));
      if (vecs[v].resp == NONE) begin
        chk($sformatf("v%0d_resp_count", v), rq.size(), 0);
      end else begin
        chk_one_resp($sformatf("v%0d_resp", v), vecs[v].resp);
        if (rc.size() > 0) chk($sformatf("v%0d_latency", v), rc[0], cr_edge + 1);
      end
    end
    chk("vec_overrun", int'(overrun), 0);

    // Idle gap aborts a partial frame with exactly one 'T'
    clear_resp();
    send_str("D12");
    idle(T + 5);
    chk_one_resp("tmo", "T");
    if (rc.size() > 0) chk("tmo_cycle", rc[0], last_edge + T + 1);
    chk("tmo_digits", int'(digits), 16'h9876);
    idle(2 * T);
    chk("tmo_once", rq.size(), 1);
    clear_resp();
    send_str("D0009#");
    idle(4);
    chk("after_tmo_digits", int'(digits), 16'h0009);
    chk_one_resp("after_tmo", "!");

    // Byte on the exact expiry cycle wins over the timeout
    clear_resp();
    send_str("D1");
    idle(T - 1);
    send_str("723#");
    idle(4);
    chk_one_resp("expiry_race", "!");
    chk("expiry_race_digits", int'(digits), 16'h1723);

    // Busy transmitter: second response overwrites the first
    clear_resp();
    tx_busy = 1'b1;
    send_str("L1#");
    send_str("X#");
    idle(5);
    chk("busy_held_count", rq.size(), 0);
    tx_busy = 1'b0;
    idle(5);
    chk_one_resp("busy_drop", "?");
    chk("busy_overrun", int'(overrun), 1);
    chk("busy_led", int'(led), 8'h01);

    // Reset in the middle of a frame
    clear_resp();
    send_str("D98");
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    clear_resp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_str("76#");
    idle(4);
    chk_one_resp("post_reset", "?");
    chk("post_reset_digits", int'(digits), 0);
    chk("post_reset_frame_err", int'(frame_err), 1);
    chk("post_reset_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
